// File: rtl/tnn_pkg.sv
// Shared types and sizing for the whitewine TNN classifier datapath.
package tnn_pkg;

    localparam int unsigned NUM_CLASSES       = 7;
    localparam int unsigned NEURONS_PER_CLASS = 8;
    localparam int unsigned CLS_W             = 3;
    localparam int unsigned CNT_W             = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CLS_W-1:0] cls_t;

    typedef enum logic [1:0] {
        ACCUM,
        SCAN,
        HOLD
    } vote_state_t;

endpackage

// File: rtl/tnn_vote_accumulator_if.sv
// Vote-beat input stream and classification-result output, both valid/ready.
interface tnn_vote_accumulator_if
    import tnn_pkg::*;
();

    logic in_valid;
    logic in_ready;
    logic in_vote;
    cls_t in_class;
    logic in_last;

    logic out_valid;
    logic out_ready;
    cls_t out_class;
    cnt_t out_score;
    logic out_tie;

    modport master (
        output in_valid, in_vote, in_class, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_tie
    );

    modport slave (
        input  in_valid, in_vote, in_class, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, out_tie
    );

endinterface

// File: rtl/tnn_sat_counter.sv
// Per-class vote counter that sticks at its maximum instead of wrapping.
module tnn_sat_counter
    import tnn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output cnt_t cnt
);

    localparam cnt_t CNT_MAX = '1;

    // Clear has priority so a new sample always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/tnn_vote_accumulator.sv
// Accumulates per-class neuron votes for one sample, then scans for the argmax
// class (lowest index wins ties) and presents it over a valid/ready handshake.
module tnn_vote_accumulator
    import tnn_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    tnn_vote_accumulator_if.slave bus
);

    localparam cls_t LAST_IDX = cls_t'(NUM_CLASSES - 1);

    vote_state_t state;
    cls_t        scan_idx;
    cnt_t        best;
    cls_t        best_idx;
    logic        tie;

    logic        in_ready_q;
    logic        out_valid_q;
    cls_t        out_class_q;
    cnt_t        out_score_q;
    logic        out_tie_q;

    cnt_t        cnt_arr [NUM_CLASSES];

    logic        accept_c;
    logic        clr_c;
    cnt_t        cur_c;
    cnt_t        nxt_best_c;
    cls_t        nxt_idx_c;
    logic        nxt_tie_c;

    // in_ready is only high in ACCUM, so this also gates counting to ACCUM.
    assign accept_c = bus.in_valid && in_ready_q;
    // out_valid is only high in HOLD; the result handshake wipes the counts.
    assign clr_c    = out_valid_q && bus.out_ready;

    genvar g;
    generate
        for (g = 0; g < NUM_CLASSES; g++) begin : g_cnt
            tnn_sat_counter u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (accept_c && bus.in_vote && (bus.in_class == cls_t'(g))),
                .clr (clr_c),
                .cnt (cnt_arr[g])
            );
        end
    endgenerate

    // One argmax step on the class selected by scan_idx.
    always_comb begin
        cur_c      = cnt_arr[scan_idx];
        nxt_best_c = best;
        nxt_idx_c  = best_idx;
        nxt_tie_c  = tie;
        if (scan_idx == '0) begin
            nxt_best_c = cur_c;
            nxt_idx_c  = '0;
            nxt_tie_c  = 1'b0;
        end else if (cur_c > best) begin
            nxt_best_c = cur_c;
            nxt_idx_c  = scan_idx;
            nxt_tie_c  = 1'b0;
        end else if (cur_c == best) begin
            nxt_tie_c  = 1'b1;
        end
    end

    // Sample sequencing: accumulate, scan one class per cycle, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACCUM;
            scan_idx    <= '0;
            best        <= '0;
            best_idx    <= '0;
            tie         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
            out_tie_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c && bus.in_last) begin
                        state      <= SCAN;
                        scan_idx   <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                SCAN: begin
                    best     <= nxt_best_c;
                    best_idx <= nxt_idx_c;
                    tie      <= nxt_tie_c;
                    if (scan_idx == LAST_IDX) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                        out_class_q <= nxt_idx_c;
                        out_score_q <= nxt_best_c;
                        out_tie_q   <= nxt_tie_c;
                    end else begin
                        scan_idx <= scan_idx + cls_t'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
    assign bus.out_tie   = out_tie_q;

endmodule

// File: tb/tb_tnn_vote_accumulator.sv
// Table-driven bench for the TNN vote accumulator with a result scoreboard.
module tb_tnn_vote_accumulator;
    import tnn_pkg::*;

    typedef struct {
        string name;
        int    votes [8];   // index 7 = out-of-range class
        int    zeros;       // extra beats with in_vote = 0
        int    exp_cls;
        int    exp_score;
        int    exp_tie;
    } vec_t;

    typedef struct packed {
        cls_t cls;
        cnt_t score;
        logic tie;
    } exp_t;

    typedef struct packed {
        logic vote;
        cls_t cls;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [$];
    vec_t vecs [9];

    tnn_vote_accumulator_if bus ();

    tnn_vote_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input int c0, input int c1, input int c2, input int c3,
                                input int c4, input int c5, input int c6, input int c7,
                                input int zeros, input int ec, input int es, input int et);
        vec_t v;
        v.name     = name;
        v.votes[0] = c0; v.votes[1] = c1; v.votes[2] = c2; v.votes[3] = c3;
        v.votes[4] = c4; v.votes[5] = c5; v.votes[6] = c6; v.votes[7] = c7;
        v.zeros     = zeros;
        v.exp_cls   = ec;
        v.exp_score = es;
        v.exp_tie   = et;
        return v;
    endfunction

    // Interleave votes round-robin across classes, then append no-vote beats.
    task automatic send_sample(input vec_t v);
        beat_t beats [$];
        int    rem [8];
        bit    any;
        for (int c = 0; c < 8; c++) rem[c] = v.votes[c];
        do begin
            any = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (rem[c] > 0) begin
                    beats.push_back('{vote: 1'b1, cls: cls_t'(c)});
                    rem[c]--;
                    any = 1'b1;
                end
            end
        end while (any);
        for (int z = 0; z < v.zeros; z++)
            beats.push_back('{vote: 1'b0, cls: cls_t'(z % NUM_CLASSES)});
        for (int b = 0; b < beats.size(); b++) begin
            bus.in_valid = 1'b1;
            bus.in_vote  = beats[b].vote;
            bus.in_class = beats[b].cls;
            bus.in_last  = (b == beats.size() - 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_vote  = 1'b0;
    endtask

    // Wait for a result, check latency and contents, optionally stall, then consume.
    task automatic collect(input string name, input int hold);
        int   cycles;
        exp_t e;
        cls_t held_cls;
        cycles = 0;
        while (!bus.out_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({name, " latency"}, cycles, NUM_CLASSES);
        if (!bus.out_valid) return;
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        chk({name, " out_class"}, int'(bus.out_class), int'(e.cls));
        chk({name, " out_score"}, int'(bus.out_score), int'(e.score));
        chk({name, " out_tie"},   int'(bus.out_tie),   int'(e.tie));
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_vote  = 1'b1;
            bus.in_class = cls_t'(0);
            bus.in_last  = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk({name, " hold in_ready"},  int'(bus.in_ready),  0);
                chk({name, " hold out_valid"}, int'(bus.out_valid), 1);
                chk({name, " hold out_score"}, int'(bus.out_score), int'(e.score));
            end
        end
        held_cls = bus.out_class;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        chk({name, " post out_valid"}, int'(bus.out_valid), 0);
        chk({name, " post in_ready"},  int'(bus.in_ready),  1);
        chk({name, " post out_class kept"}, int'(bus.out_class), int'(held_cls));
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        sb_q.push_back('{cls: cls_t'(v.exp_cls), score: cnt_t'(v.exp_score), tie: v.exp_tie[0]});
        send_sample(v);
        collect(v.name, hold);
    endtask

    initial begin
        vecs[0] = mk("all8",     8, 8, 8, 8, 8, 8, 8, 0, 0, 0, NEURONS_PER_CLASS, 1);
        vecs[1] = mk("c3x5c5x2", 0, 0, 0, 5, 0, 2, 0, 0, 0, 3, 5, 0);
        vecs[2] = mk("sat6",     0, 0, 0, 0, 0, 0, 20, 0, 0, 6, 15, 0);
        vecs[3] = mk("badcls",   0, 0, 1, 0, 0, 0, 0, 4, 0, 2, 1, 0);
        vecs[4] = mk("novotes",  0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1);
        vecs[5] = mk("single",   0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0);
        vecs[6] = mk("tie2_5",   0, 1, 3, 0, 0, 3, 0, 0, 0, 2, 3, 1);
        vecs[7] = mk("tieclear", 2, 2, 0, 5, 0, 0, 0, 0, 0, 3, 5, 0);
        vecs[8] = mk("late6",    3, 0, 0, 0, 0, 0, 4, 0, 2, 6, 4, 0);

        bus.in_valid  = 1'b0;
        bus.in_vote   = 1'b0;
        bus.in_class  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("reset in_ready",  int'(bus.in_ready),  1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_class", int'(bus.out_class), 0);
        chk("reset out_score", int'(bus.out_score), 0);
        chk("reset out_tie",   int'(bus.out_tie),   0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 0);

        // Stall the consumer with a beat offered; it must not be taken.
        run_vec(mk("stall", 1, 0, 0, 0, 2, 0, 0, 0, 0, 4, 2, 0), 10);
        run_vec(mk("afterstall", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1, 0), 0);

        // Abort a sample mid-scan with an asynchronous reset.
        send_sample(mk("abort", 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort out_valid", int'(bus.out_valid), 0);
        chk("abort in_ready",  int'(bus.in_ready),  1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(mk("postabort", 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), 0);

        chk("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
